// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// the HI/LO result payload and the latency-counter width helper.
package mdu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Full-width result as it is written into {HI, LO}
    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_t;

    // Counter must hold the longest latency value
    function automatic int unsigned cnt_width(input int unsigned mult_cycles,
                                              input int unsigned div_cycles);
        int unsigned longest;
        longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed behaviourally at launch and committed after a fixed
// latency that stands in for an iterative datapath.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle launch pulse for mdu_op
//   mdu_op     : operation select (see mdu_pkg::mdu_op_e)
//   A1, A2     : rs / rt operands
//   rd_sel     : 0 reads LO, 1 reads HI on mdu_res
//   busy       : high while a mult/div is in flight
//   mdu_res    : combinational read of committed HI or LO
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A1,
    input  logic [31:0] A2,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] mdu_res
);

    localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    mdu_state_e         state;
    mdu_state_e         state_next;
    logic [CNT_W-1:0]   cnt;
    hilo_t              pend;
    logic               pend_zero;
    logic [DATA_W-1:0]  hi_q;
    logic [DATA_W-1:0]  lo_q;

    logic               is_mul;
    logic               is_div;
    logic               launch;
    logic               last_cycle;
    logic               commit;
    logic               wr_hi;
    logic               wr_lo;

    hilo_t              res;
    logic               div_zero;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [DATA_W-1:0]  abs_a;
    logic [DATA_W-1:0]  abs_b;
    logic [DATA_W-1:0]  div_bs;
    logic [DATA_W-1:0]  div_bu;
    logic [DATA_W-1:0]  uq_s;
    logic [DATA_W-1:0]  ur_s;

    // Operation class decode
    always_comb begin
        is_mul = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
        is_div = (mdu_op == MDU_DIV)  || (mdu_op == MDU_DIVU);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start && (is_mul || is_div)) state_next = ST_BUSY;
            ST_BUSY: if (cnt == CNT_W'(1))            state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath strobes
    always_comb begin
        busy       = 1'b0;
        launch     = 1'b0;
        last_cycle = 1'b0;
        commit     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (state)
            ST_IDLE: begin
                launch = start && (is_mul || is_div);
                wr_hi  = start && (mdu_op == MDU_MTHI);
                wr_lo  = start && (mdu_op == MDU_MTLO);
            end
            ST_BUSY: begin
                busy       = 1'b1;
                last_cycle = (cnt == CNT_W'(1));
                commit     = last_cycle && !pend_zero;
            end
            default: ;
        endcase
    end

    // Signed division on magnitudes so overflow and truncation toward zero
    // fall out naturally; a zero divisor is replaced by 1 to keep the
    // arithmetic defined (its result is discarded anyway).
    always_comb begin
        prod_s = {{32{A1[31]}}, A1} * {{32{A2[31]}}, A2};
        prod_u = {32'd0, A1} * {32'd0, A2};
        abs_a  = A1[31] ? (32'd0 - A1) : A1;
        abs_b  = A2[31] ? (32'd0 - A2) : A2;
        div_bs = (A2 == 32'd0) ? 32'd1 : abs_b;
        div_bu = (A2 == 32'd0) ? 32'd1 : A2;
        uq_s   = abs_a / div_bs;
        ur_s   = abs_a % div_bs;
    end

    // Result select for the launching operation
    always_comb begin
        res      = '0;
        div_zero = 1'b0;
        case (mdu_op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV: begin
                res.lo   = (A1[31] ^ A2[31]) ? (32'd0 - uq_s) : uq_s;
                res.hi   = A1[31] ? (32'd0 - ur_s) : ur_s;
                div_zero = (A2 == 32'd0);
            end
            MDU_DIVU: begin
                res.lo   = A1 / div_bu;
                res.hi   = A1 % div_bu;
                div_zero = (A2 == 32'd0);
            end
            default: ;
        endcase
    end

    // Pending result, latency counter and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            pend      <= '0;
            pend_zero <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            if (launch) begin
                pend      <= res;
                pend_zero <= div_zero;
                cnt       <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                hi_q <= pend.hi;
                lo_q <= pend.lo;
            end
            if (wr_hi) hi_q <= A1;
            if (wr_lo) lo_q <= A1;
        end
    end

    assign mdu_res = rd_sel ? hi_q : lo_q;

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Where the ALU answers combinationally from `alu_op`, this block accepts operations through a start/busy handshake.
- It owns the architectural HI/LO registers and serves mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- The hazard unit stalls any MDU-class instruction in decode while `start` or `busy` is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle launch pulse for the operation on `mdu_op`
- mdu_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, others treated as none
- A1  input  32  rs operand; dividend/multiplicand; source for mthi/mtlo
- A2  input  32  rt operand; divisor/multiplier
- rd_sel  input  1  0 selects LO, 1 selects HI on `mdu_res`
- busy  output  1  high while a mult or div is in flight
- mdu_res  output  32  combinational read of the committed HI or LO register

Behaviour:
- Reset (synchronous, priority over everything)
  - HI=0, LO=0, busy=0, counter=0, pending results=0.
  - Asserting reset mid-operation aborts it; no result is ever committed.
- Launch: at a posedge with start=1, busy=0, op in 1..4
  - Full results are computed from A1/A2 into pending_hi/pending_lo.
  - counter is loaded with MULT_CYCLES or DIV_CYCLES; busy=1 from that edge.
- Countdown
  - Each posedge with busy=1 decrements counter.
  - At the edge where counter goes 1->0: HI/LO take pending values and busy=0.
  - busy is therefore high for exactly N cycles; new HI/LO are visible on `mdu_res` in the first cycle busy is low.
- mthi/mtlo (start=1, busy=0)
  - HI (or LO) takes A1 at that edge; busy stays 0.
  - The written value is readable the next cycle.
- start=1 while busy=1: ignored entirely. There is no queueing and the in-flight operation is unaffected.
- start=1 with op 0 or 7..15: no state change.
- mult: {HI,LO} = signed(A1) * signed(A2), 64-bit.
- multu: {HI,LO} = A1 * A2 unsigned, 64-bit.
- div/divu: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0: operation still runs DIV_CYCLES with busy high, but HI/LO are left unchanged at completion.
- Operands are captured at launch; changes on A1/A2 during busy have no effect.
- mdu_res = rd_sel ? HI : LO, from committed registers only; pending values are never visible.
- A read during busy returns the old value. The stall logic prevents mfhi/mflo from issuing in that window.

Decomposition:
- Shared package (mdu_pkg)
  - mdu_op encodings MDU_NONE..MDU_MTLO.
  - Counter width derived as clog2(max(MULT_CYCLES, DIV_CYCLES) + 1).
- Datapath: single flat module. The multiplier/divider is behavioural, computed at launch; the latency counter models the iterative timing.
- No sub-module required. If a real iterative divider replaces the behavioural one later, it becomes sub-module mdu_div_iter, with a start/done handshake internal to mdu.

Test Plan:
- Reset then mult
  - Stimulus: reset, then start mult with A1=0xFFFFFFFE (-2), A2=3.
  - Required: busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu
  - Stimulus: A1=0xFFFFFFFF, A2=2.
  - Required: after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div
  - Stimulus: A1=-7 (0xFFFFFFF9), A2=2.
  - Required: busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Divide by zero and divu
  - Stimulus: mthi 0x1234, mtlo 0x5678, then divu A1=9, A2=0.
  - Required: busy 10 cycles; HI=0x1234, LO=0x5678 unchanged.
  - Stimulus: divu A1=9, A2=4.
  - Required: LO=2, HI=1.
- Start while busy
  - Stimulus: start mult 2*3; on busy cycle 2, start div 100/7 with A1 changed.
  - Required: second start ignored; busy falls after 5 cycles total; LO=6, HI=0.
- Reset mid-operation
  - Stimulus: start div 100/7, assert reset on busy cycle 4.
  - Required: the next cycle shows busy=0, HI=0, LO=0; no late commit in the following 10 cycles.
